// File: rtl/keypad_scan.sv
// Column-scanning driver and debouncer for a 4x4 active-low matrix keypad.
// Presents a debounced 5-bit keycode ({1,hex} or 0) and a new-key strobe.
module keypad_scan #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [4:0] keycode,
  output logic       key_press
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [1:0]       acc_hits;
  logic [3:0]       acc_hex;
  logic [4:0]       cand;
  logic [CNT_W-1:0] cnt;

  logic             sample_c, last_col_c;
  logic [3:0]       low_c;
  logic [2:0]       low_n_c, hit_sum_c;
  logic [1:0]       row_pos_c, base_hits_c, hits_nx_c;
  logic [3:0]       base_hex_c, hex_nx_c;
  logic [4:0]       result_c, cand_nx_c, keycode_nx_c;
  logic [CNT_W-1:0] cnt_nx_c;
  logic             press_nx_c;

  function automatic logic [3:0] key_hex(input logic [1:0] c, input logic [1:0] r);
    case ({c, r})
      4'h0: key_hex = 4'h1;  4'h1: key_hex = 4'h4;  4'h2: key_hex = 4'h7;  4'h3: key_hex = 4'h0;
      4'h4: key_hex = 4'h2;  4'h5: key_hex = 4'h5;  4'h6: key_hex = 4'h8;  4'h7: key_hex = 4'hF;
      4'h8: key_hex = 4'h3;  4'h9: key_hex = 4'h6;  4'hA: key_hex = 4'h9;  4'hB: key_hex = 4'hE;
      4'hC: key_hex = 4'hA;  4'hD: key_hex = 4'hB;  4'hE: key_hex = 4'hC;  default: key_hex = 4'hD;
    endcase
  endfunction

  // Per-column hit accumulation; column 0 starts a fresh scan, hit count saturates at 2.
  always_comb begin
    sample_c    = (div == DIV_LAST);
    last_col_c  = sample_c && (col_idx == 2'd3);
    low_c       = ~row_sync;
    low_n_c     = 3'(low_c[0]) + 3'(low_c[1]) + 3'(low_c[2]) + 3'(low_c[3]);
    row_pos_c   = 2'd3;
    if (low_c[0])      row_pos_c = 2'd0;
    else if (low_c[1]) row_pos_c = 2'd1;
    else if (low_c[2]) row_pos_c = 2'd2;
    base_hits_c = (col_idx == 2'd0) ? 2'd0 : acc_hits;
    base_hex_c  = (col_idx == 2'd0) ? 4'h0 : acc_hex;
    hit_sum_c   = 3'(base_hits_c) + low_n_c;
    hits_nx_c   = (hit_sum_c >= 3'd2) ? 2'd2 : hit_sum_c[1:0];
    hex_nx_c    = (low_n_c == 3'd1) ? key_hex(col_idx, row_pos_c) : base_hex_c;
    result_c    = (hits_nx_c == 2'd1) ? {1'b1, hex_nx_c} : 5'h00;
  end

  // Debounce: keycode follows a candidate that held for DEBOUNCE_SCANS full scans.
  always_comb begin
    cand_nx_c    = cand;
    cnt_nx_c     = cnt;
    keycode_nx_c = keycode;
    press_nx_c   = 1'b0;
    if (last_col_c) begin
      if (result_c == cand) begin
        cnt_nx_c = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      end else begin
        cand_nx_c = result_c;
        cnt_nx_c  = CNT_W'(1);
      end
      if ((cnt_nx_c == CNT_MAX) && (cand_nx_c != keycode)) begin
        keycode_nx_c = cand_nx_c;
        press_nx_c   = (cand_nx_c != 5'h00);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta  <= 4'b1111;
      row_sync  <= 4'b1111;
      div       <= '0;
      col_idx   <= 2'd0;
      col       <= 4'b1110;
      acc_hits  <= 2'd0;
      acc_hex   <= 4'h0;
      cand      <= 5'h00;
      cnt       <= '0;
      keycode   <= 5'h00;
      key_press <= 1'b0;
    end else begin
      row_meta  <= row;
      row_sync  <= row_meta;
      div       <= sample_c ? '0 : div + DIV_W'(1);
      if (sample_c) begin
        col_idx  <= col_idx + 2'd1;
        col      <= {col[2:0], col[3]};
        acc_hits <= hits_nx_c;
        acc_hex  <= hex_nx_c;
      end
      cand      <= cand_nx_c;
      cnt       <= cnt_nx_c;
      keycode   <= keycode_nx_c;
      key_press <= press_nx_c;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a keypad model drives rows from col,
// and a scan-level reference model predicts keycode and key_press per cycle.
module tb_keypad_scan;

  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned DEB      = 3;
  localparam int unsigned SCAN_CYC = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [4:0] keycode;
  logic       key_press;

  logic [15:0] pressed = '0;
  int checks = 0;
  int errors = 0;
  int press_seen = 0;
  logic [4:0] exp_key = 5'h00;
  logic       exp_press = 1'b0;
  logic [4:0] hist[$];
  logic [3:0] hexmap [16] = '{4'h1, 4'h4, 4'h7, 4'h0,
                              4'h2, 4'h5, 4'h8, 4'hF,
                              4'h3, 4'h6, 4'h9, 4'hE,
                              4'hA, 4'hB, 4'hC, 4'hD};

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .keycode(keycode), .key_press(key_press)
  );

  always #5 clk = ~clk;

  // Key (c,r) is bit c*4+r of pressed; it pulls row r low while col c is low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && pressed[c*4+r]) row[r] = 1'b0;
  end

  function automatic logic [15:0] key(input int c, input int r);
    logic [15:0] k;
    k = '0;
    k[c*4+r] = 1'b1;
    return k;
  endfunction

  function automatic logic [4:0] scan_result(input logic [15:0] k);
    if ($countones(k) != 1) return 5'h00;
    for (int i = 0; i < 16; i++)
      if (k[i]) return {1'b1, hexmap[i]};
    return 5'h00;
  endfunction

  // Keycode follows a value once the last DEB scan results all agree on it.
  task automatic model_scan(input logic [15:0] k);
    logic [4:0] res;
    logic all_eq;
    res = scan_result(k);
    hist.push_back(res);
    if (hist.size() > DEB) void'(hist.pop_front());
    exp_press = 1'b0;
    if (hist.size() == DEB) begin
      all_eq = 1'b1;
      foreach (hist[i]) if (hist[i] != res) all_eq = 1'b0;
      if (all_eq && res != exp_key) begin
        exp_key   = res;
        exp_press = (res != 5'h00);
      end
    end
  endtask

  // Called in the first cycle of a scan; leaves the bench in the first cycle of the next.
  task automatic run_scan(input logic [15:0] k);
    logic [3:0] ec;
    logic       ep;
    pressed = k;
    for (int i = 0; i < int'(SCAN_CYC); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      ec = ~(4'b0001 << (i / int'(SCAN_DIV)));
      ep = (i == 0) ? exp_press : 1'b0;
      checks++;
      if (col !== ec) begin
        errors++;
        $display("FAIL col cyc=%0d got=%b exp=%b", i, col, ec);
      end
      checks++;
      if (keycode !== exp_key) begin
        errors++;
        $display("FAIL keycode cyc=%0d got=%h exp=%h", i, keycode, exp_key);
      end
      checks++;
      if (key_press !== ep) begin
        errors++;
        $display("FAIL key_press cyc=%0d got=%b exp=%b", i, key_press, ep);
      end
      if (key_press === 1'b1) press_seen++;
    end
    model_scan(k);
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    hist.delete();
    exp_key   = 5'h00;
    exp_press = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (col !== 4'b1110 || keycode !== 5'h00 || key_press !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got col=%b key=%h press=%b exp col=1110 key=00 press=0",
               col, keycode, key_press);
    end
    rst_n = 1'b1;
    model_clear();
    run_scan('0);
    run_scan('0);
  endtask

  task automatic test_hold_key5();
    int p0;
    p0 = press_seen;
    repeat (3) run_scan(key(1, 1));
    checks++;
    if (keycode !== 5'h15) begin
      errors++;
      $display("FAIL hold5_keycode got=%h exp=15", keycode);
    end
    repeat (10) run_scan(key(1, 1));
    checks++;
    if (press_seen - p0 != 1) begin
      errors++;
      $display("FAIL hold5_pulses got=%0d exp=1", press_seen - p0);
    end
  endtask

  task automatic test_release();
    int p0;
    p0 = press_seen;
    repeat (3) run_scan('0);
    run_scan('0);
    checks++;
    if (keycode !== 5'h00 || press_seen != p0) begin
      errors++;
      $display("FAIL release got key=%h pulses=%0d exp key=00 pulses=0", keycode, press_seen - p0);
    end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = press_seen;
    for (int s = 0; s < 12; s++) run_scan((s % 2 == 0) ? key(3, 3) : 16'h0000);
    run_scan('0);
    checks++;
    if (keycode !== 5'h00 || press_seen != p0) begin
      errors++;
      $display("FAIL bounce got key=%h pulses=%0d exp key=00 pulses=0", keycode, press_seen - p0);
    end
  endtask

  task automatic test_multi_and_switch();
    int p0;
    p0 = press_seen;
    repeat (4) run_scan(key(0, 0) | key(1, 0));
    checks++;
    if (keycode !== 5'h00) begin
      errors++;
      $display("FAIL ghost got=%h exp=00", keycode);
    end
    repeat (3) run_scan(key(0, 0));
    checks++;
    if (keycode !== 5'h11) begin
      errors++;
      $display("FAIL key1 got=%h exp=11", keycode);
    end
    repeat (3) run_scan(key(1, 0));
    checks++;
    if (keycode !== 5'h12) begin
      errors++;
      $display("FAIL key2 got=%h exp=12", keycode);
    end
    run_scan(key(1, 0));
    checks++;
    if (press_seen - p0 != 2) begin
      errors++;
      $display("FAIL switch_pulses got=%0d exp=2", press_seen - p0);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    repeat (3) run_scan(key(3, 0));
    checks++;
    if (keycode !== 5'h1A || key_press !== 1'b1) begin
      errors++;
      $display("FAIL keyA_pre got key=%h press=%b exp key=1a press=1", keycode, key_press);
    end
    repeat (13) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (col !== 4'b1110 || keycode !== 5'h00 || key_press !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got col=%b key=%h press=%b exp col=1110 key=00 press=0",
               col, keycode, key_press);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    p0 = press_seen;
    repeat (4) run_scan(key(3, 0));
    checks++;
    if (keycode !== 5'h1A || press_seen - p0 != 1) begin
      errors++;
      $display("FAIL keyA_post got key=%h pulses=%0d exp key=1a pulses=1", keycode, press_seen - p0);
    end
  endtask

  task automatic test_random();
    logic [15:0] k;
    int kind, hold;
    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 3));
      hold = int'($urandom_range(1, 4));
      k = '0;
      if (kind >= 1) k = k | key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if (kind == 3) k = k | key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      repeat (hold) run_scan(k);
    end
  endtask

  initial begin
    test_reset();
    test_hold_key5();
    test_release();
    test_bounce();
    test_multi_and_switch();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
